// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: bundles the fetch port (F), loader port (L) and spram port
//    of the instruction-memory arbiter.
// Latency: none, this is wiring only.
// Backpressure: F and L hold their requests until they see gnt; the spram
//    port has no backpressure.
// Ports: none; clk/reset are carried separately by the modules.
// Modport slave  = arbiter view (drives gnt/rsp and mem_*, samples requests and mem_rdata).
// Modport master = environment view (drives requests and mem_rdata).
interface imem_arbiter_if #(
   parameter int AW = 10,
   parameter int DW = 32
) ();
   // fetch port (read-only)
   logic          f_req;
   logic [AW-1:0] f_addr;
   logic          f_gnt;
   logic          f_rvalid;
   logic [DW-1:0] f_rdata;
   logic          f_err;
   // loader / debug port
   logic          l_req;
   logic          l_we;
   logic [AW-1:0] l_addr;
   logic [DW-1:0] l_wdata;
   logic          l_gnt;
   logic          l_rvalid;
   logic [DW-1:0] l_rdata;
   logic          l_err;
   logic          l_hold;
   // spram
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  f_req, f_addr,
      output f_gnt, f_rvalid, f_rdata, f_err,
      input  l_req, l_we, l_addr, l_wdata, l_hold,
      output l_gnt, l_rvalid, l_rdata, l_err,
      output mem_addr, mem_we, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output f_req, f_addr,
      input  f_gnt, f_rvalid, f_rdata, f_err,
      output l_req, l_we, l_addr, l_wdata, l_hold,
      input  l_gnt, l_rvalid, l_rdata, l_err,
      input  mem_addr, mem_we, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: arbitrates fetch (F) and loader (L) onto one spram; grants are
//    combinational, and a starvation counter forces L through under a steady fetch.
// Latency: the access is granted in the request cycle and the response is
//    tagged to its owner exactly one cycle after the grant.
// Backpressure: a requester that is not granted holds its request; each
//    response is a single-cycle pulse that cannot be stalled.
// Ports: clk, reset (synchronous, active-high), bus (imem_arbiter_if.slave).
module imem_arbiter #(
   parameter int AW       = 10,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic           clk,
   input  logic           reset,
   imem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_F    = 2'd1,
      OWN_L    = 2'd2
   } owner_e;

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   // response tag registered in the grant cycle
   owner_e        rsp_owner_q, rsp_owner_d;
   logic          rsp_err_q,   rsp_err_d;
   logic          rsp_we_q,    rsp_we_d;
   // consecutive cycles L has been denied
   logic [3:0]    wait_cnt_q,  wait_cnt_d;
   // last driven spram address / write data, held while idle
   logic [AW-1:0] addr_q,      addr_d;
   logic [DW-1:0] wdata_q,     wdata_d;

   logic          f_gnt, l_gnt;
   logic          f_mis, l_mis;
   logic          mem_we;
   logic          f_rvalid, l_rvalid;

   assign f_mis = (bus.f_addr[1:0] != 2'b00);
   assign l_mis = (bus.l_addr[1:0] != 2'b00);

   // grant selection; nothing is granted while reset is high, so a request
   // presented in the reset cycle never produces a response
   always_comb begin
      f_gnt = 1'b0;
      l_gnt = 1'b0;
      if (!reset) begin
         if (bus.l_hold) begin
            l_gnt = bus.l_req;
         end else if ((wait_cnt_q == MAX_WAIT_C) && bus.l_req) begin
            l_gnt = 1'b1;
         end else if (bus.f_req) begin
            f_gnt = 1'b1;
         end else if (bus.l_req) begin
            l_gnt = 1'b1;
         end
      end
   end

   // memory drive and response tagging
   always_comb begin
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      mem_we      = 1'b0;
      rsp_owner_d = OWN_NONE;
      rsp_err_d   = 1'b0;
      rsp_we_d    = 1'b0;
      if (f_gnt) begin
         rsp_owner_d = OWN_F;
         rsp_err_d   = f_mis;
         if (!f_mis) begin
            addr_d = bus.f_addr;
         end
      end else if (l_gnt) begin
         rsp_owner_d = OWN_L;
         rsp_err_d   = l_mis;
         rsp_we_d    = bus.l_we;
         // a misaligned access is granted but never touches the spram
         if (!l_mis) begin
            addr_d = bus.l_addr;
            mem_we = bus.l_we;
            if (bus.l_we) begin
               wdata_d = bus.l_wdata;
            end
         end
      end
   end

   // starvation counter: counts denied L cycles, saturates at MAX_WAIT
   always_comb begin
      wait_cnt_d = 4'd0;
      if (bus.l_req && !l_gnt) begin
         wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? MAX_WAIT_C : (wait_cnt_q + 4'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_owner_q <= OWN_NONE;
         rsp_err_q   <= 1'b0;
         rsp_we_q    <= 1'b0;
         wait_cnt_q  <= 4'd0;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         rsp_owner_q <= rsp_owner_d;
         rsp_err_q   <= rsp_err_d;
         rsp_we_q    <= rsp_we_d;
         wait_cnt_q  <= wait_cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
      end
   end

   // responses are suppressed while reset is high so every output reads 0
   assign f_rvalid = !reset && (rsp_owner_q == OWN_F);
   assign l_rvalid = !reset && (rsp_owner_q == OWN_L);

   assign bus.f_gnt     = f_gnt;
   assign bus.l_gnt     = l_gnt;
   assign bus.f_rvalid  = f_rvalid;
   assign bus.l_rvalid  = l_rvalid;
   assign bus.f_err     = f_rvalid && rsp_err_q;
   assign bus.l_err     = l_rvalid && rsp_err_q;
   assign bus.f_rdata   = (f_rvalid && !rsp_err_q) ? bus.mem_rdata : '0;
   assign bus.l_rdata   = (l_rvalid && !rsp_err_q && !rsp_we_q) ? bus.mem_rdata : '0;
   assign bus.mem_we    = mem_we;
   assign bus.mem_addr  = reset ? '0 : addr_d;
   assign bus.mem_wdata = reset ? '0 : wdata_d;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed bench for imem_arbiter with a behavioural spram.
// Latency: inputs change 1 time unit after posedge; combinational outputs are
//    sampled 3 units later and registered responses just after the next posedge.
// Backpressure: stimulus holds requests until the expected grant.
module tb_imem_arbiter;
   localparam int AW = 10;
   localparam int DW = 32;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   imem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   imem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // spram: synchronous read, one-cycle latency, read-first on a same-cycle write
   logic [DW-1:0] mem [256];
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr[AW-1:2]] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr[AW-1:2]];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic idle();
      bus.f_req   = 1'b0;
      bus.f_addr  = '0;
      bus.l_req   = 1'b0;
      bus.l_we    = 1'b0;
      bus.l_addr  = '0;
      bus.l_wdata = '0;
      bus.l_hold  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.f_req = 1'b1; bus.f_addr = 10'd8;
      bus.l_req = 1'b1; bus.l_addr = 10'd4;
      for (int i = 0; i < 2; i++) begin
         tick();
         settle();
         total++; if ({bus.f_gnt, bus.l_gnt} !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b want=00", {bus.f_gnt, bus.l_gnt}); end
         total++; if ({bus.f_rvalid, bus.l_rvalid, bus.mem_we} !== 3'b000) begin bad++; $display("FAIL reset_rvalid_we got=%b want=000", {bus.f_rvalid, bus.l_rvalid, bus.mem_we}); end
         total++; if (bus.mem_addr !== 10'd0) begin bad++; $display("FAIL reset_mem_addr got=%0d want=0", bus.mem_addr); end
      end
      tick();
      reset = 1'b0;
      settle();
      total++; if ({bus.f_gnt, bus.l_gnt} !== 2'b10) begin bad++; $display("FAIL first_gnt got=%b want=10", {bus.f_gnt, bus.l_gnt}); end
      tick();
      total++; if ({bus.f_rvalid, bus.l_rvalid} !== 2'b10) begin bad++; $display("FAIL first_rvalid got=%b want=10", {bus.f_rvalid, bus.l_rvalid}); end
      idle();
      tick();
   endtask

   task automatic test_single_fetch();
      bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 10'd4; bus.l_wdata = 32'hDEADBEEF;
      settle();
      total++; if ({bus.l_gnt, bus.mem_we} !== 2'b11) begin bad++; $display("FAIL wr_gnt_we got=%b want=11", {bus.l_gnt, bus.mem_we}); end
      total++; if (bus.mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_wdata got=%h want=deadbeef", bus.mem_wdata); end
      tick();
      total++; if ({bus.l_rvalid, bus.l_err, bus.f_rvalid} !== 3'b100) begin bad++; $display("FAIL wr_rsp got=%b want=100", {bus.l_rvalid, bus.l_err, bus.f_rvalid}); end
      total++; if (bus.l_rdata !== 32'h0) begin bad++; $display("FAIL wr_rdata got=%h want=0", bus.l_rdata); end
      idle();
      bus.f_req = 1'b1; bus.f_addr = 10'd4;
      settle();
      total++; if ({bus.f_gnt, bus.mem_we} !== 2'b10) begin bad++; $display("FAIL fetch_gnt got=%b want=10", {bus.f_gnt, bus.mem_we}); end
      total++; if (bus.mem_addr !== 10'd4) begin bad++; $display("FAIL fetch_addr got=%0d want=4", bus.mem_addr); end
      tick();
      idle();
      total++; if ({bus.f_rvalid, bus.f_err, bus.l_rvalid} !== 3'b100) begin bad++; $display("FAIL fetch_rsp got=%b want=100", {bus.f_rvalid, bus.f_err, bus.l_rvalid}); end
      total++; if (bus.f_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL fetch_rdata got=%h want=deadbeef", bus.f_rdata); end
      settle();
      total++; if (bus.mem_addr !== 10'd4) begin bad++; $display("FAIL idle_hold_addr got=%0d want=4", bus.mem_addr); end
      tick();
   endtask

   task automatic test_starvation();
      bus.f_req = 1'b1; bus.f_addr = 10'd8;
      bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 10'd4;
      for (int k = 0; k < 6; k++) begin
         settle();
         if (k < 4) begin
            total++; if ({bus.f_gnt, bus.l_gnt} !== 2'b10) begin bad++; $display("FAIL starve_f%0d got=%b want=10", k, {bus.f_gnt, bus.l_gnt}); end
         end else if (k == 4) begin
            total++; if ({bus.f_gnt, bus.l_gnt} !== 2'b01) begin bad++; $display("FAIL starve_l got=%b want=01", {bus.f_gnt, bus.l_gnt}); end
         end else begin
            total++; if ({bus.f_gnt, bus.l_gnt} !== 2'b10) begin bad++; $display("FAIL starve_resume got=%b want=10", {bus.f_gnt, bus.l_gnt}); end
            total++; if (dut.wait_cnt_q !== 4'd0) begin bad++; $display("FAIL starve_cnt got=%0d want=0", dut.wait_cnt_q); end
         end
         tick();
         if (k == 4) begin
            total++; if ({bus.l_rvalid, bus.f_rvalid} !== 2'b10) begin bad++; $display("FAIL starve_lrsp got=%b want=10", {bus.l_rvalid, bus.f_rvalid}); end
            total++; if (bus.l_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL starve_ldata got=%h want=deadbeef", bus.l_rdata); end
            bus.l_req = 1'b0;
         end
      end
      idle();
      tick();
   endtask

   task automatic test_hold();
      bus.l_hold = 1'b1;
      bus.f_req = 1'b1; bus.f_addr = 10'd8;
      bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 10'd4;
      for (int i = 0; i < 6; i++) begin
         settle();
         total++; if ({bus.f_gnt, bus.l_gnt} !== 2'b01) begin bad++; $display("FAIL hold_gnt%0d got=%b want=01", i, {bus.f_gnt, bus.l_gnt}); end
         tick();
         total++; if ({bus.f_rvalid, bus.l_rvalid} !== 2'b01) begin bad++; $display("FAIL hold_rsp%0d got=%b want=01", i, {bus.f_rvalid, bus.l_rvalid}); end
      end
      bus.l_hold = 1'b0; bus.l_req = 1'b0;
      settle();
      total++; if ({bus.f_gnt, bus.l_gnt} !== 2'b10) begin bad++; $display("FAIL hold_release got=%b want=10", {bus.f_gnt, bus.l_gnt}); end
      tick();
      idle();
      tick();
   endtask

   task automatic test_misaligned();
      bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 10'd6; bus.l_wdata = 32'h12345678;
      settle();
      total++; if ({bus.l_gnt, bus.mem_we} !== 2'b10) begin bad++; $display("FAIL mis_gnt_we got=%b want=10", {bus.l_gnt, bus.mem_we}); end
      tick();
      total++; if ({bus.l_rvalid, bus.l_err} !== 2'b11) begin bad++; $display("FAIL mis_rsp got=%b want=11", {bus.l_rvalid, bus.l_err}); end
      total++; if (bus.l_rdata !== 32'h0) begin bad++; $display("FAIL mis_rdata got=%h want=0", bus.l_rdata); end
      bus.l_we = 1'b0; bus.l_addr = 10'd4;
      tick();
      total++; if ({bus.l_rvalid, bus.l_err} !== 2'b10) begin bad++; $display("FAIL mis_reread_rsp got=%b want=10", {bus.l_rvalid, bus.l_err}); end
      total++; if (bus.l_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL mis_reread_data got=%h want=deadbeef", bus.l_rdata); end
      idle();
      bus.f_req = 1'b1; bus.f_addr = 10'd5;
      tick();
      idle();
      total++; if ({bus.f_rvalid, bus.f_err, bus.f_rdata} !== {2'b11, 32'h0}) begin bad++; $display("FAIL mis_fetch got=%b/%h want=11/0", {bus.f_rvalid, bus.f_err}, bus.f_rdata); end
      tick();
   endtask

   task automatic test_back_to_back();
      // write 0xA5A50F0F to 8, then F reads 4, L reads 8, F reads 8
      bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 10'd8; bus.l_wdata = 32'hA5A50F0F;
      tick();
      idle();
      bus.f_req = 1'b1; bus.f_addr = 10'd4;
      settle();
      total++; if (bus.f_gnt !== 1'b1) begin bad++; $display("FAIL b2b_g0 got=%b want=1", bus.f_gnt); end
      tick();
      total++; if ({bus.f_rvalid, bus.l_rvalid, bus.f_rdata} !== {2'b10, 32'hDEADBEEF}) begin bad++; $display("FAIL b2b_r0 got=%b/%h want=10/deadbeef", {bus.f_rvalid, bus.l_rvalid}, bus.f_rdata); end
      idle();
      bus.l_req = 1'b1; bus.l_addr = 10'd8;
      settle();
      total++; if (bus.l_gnt !== 1'b1) begin bad++; $display("FAIL b2b_g1 got=%b want=1", bus.l_gnt); end
      tick();
      total++; if ({bus.f_rvalid, bus.l_rvalid, bus.l_rdata} !== {2'b01, 32'hA5A50F0F}) begin bad++; $display("FAIL b2b_r1 got=%b/%h want=01/a5a50f0f", {bus.f_rvalid, bus.l_rvalid}, bus.l_rdata); end
      idle();
      bus.f_req = 1'b1; bus.f_addr = 10'd8;
      tick();
      idle();
      total++; if ({bus.f_rvalid, bus.l_rvalid, bus.f_rdata} !== {2'b10, 32'hA5A50F0F}) begin bad++; $display("FAIL b2b_r2 got=%b/%h want=10/a5a50f0f", {bus.f_rvalid, bus.l_rvalid}, bus.f_rdata); end
      tick();
   endtask

   task automatic test_reset_midop();
      bus.f_req = 1'b1; bus.f_addr = 10'd4;
      bus.l_req = 1'b1; bus.l_addr = 10'd8;
      settle();
      total++; if (bus.f_gnt !== 1'b1) begin bad++; $display("FAIL midop_pre_gnt got=%b want=1", bus.f_gnt); end
      tick();
      tick();
      reset = 1'b1;
      settle();
      total++; if ({bus.f_gnt, bus.l_gnt} !== 2'b00) begin bad++; $display("FAIL midop_rst_gnt got=%b want=00", {bus.f_gnt, bus.l_gnt}); end
      tick();
      reset = 1'b0;
      idle();
      total++; if ({bus.f_rvalid, bus.l_rvalid} !== 2'b00) begin bad++; $display("FAIL midop_dropped got=%b want=00", {bus.f_rvalid, bus.l_rvalid}); end
      total++; if (dut.wait_cnt_q !== 4'd0) begin bad++; $display("FAIL midop_cnt got=%0d want=0", dut.wait_cnt_q); end
      tick();
      total++; if ({bus.f_rvalid, bus.l_rvalid} !== 2'b00) begin bad++; $display("FAIL midop_quiet got=%b want=00", {bus.f_rvalid, bus.l_rvalid}); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      idle();
      reset = 1'b1;
      test_reset();
      test_single_fetch();
      test_starvation();
      test_hold();
      test_misaligned();
      test_back_to_back();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
